alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: keypad-driven ALU sequencer. A synchronized rising edge on
// FINISH launches one calculation (IDLE -> LOAD -> EXEC -> DONE). MUL and DIV
// iterate one bit per EXEC cycle; all other ops finish in a single EXEC cycle.
module alu_sequencer #(
    parameter int unsigned OPW = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [OPW-1:0]       SRC,
    input  logic [OPW-1:0]       DST,
    input  logic [2:0]           ALU_OP,
    input  logic                 FINISH,
    output logic [2*OPW-1:0]     RESULT,
    output logic                 VALID,
    output logic                 BUSY,
    output logic                 NEG,
    output logic                 ERR
);

    localparam int unsigned RW = 2 * OPW;
    localparam int unsigned CW = (OPW > 1) ? $clog2(OPW) : 1;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FINISH synchronizer, edge flop and post-reset fill tracker
    logic          r_sync1;
    logic          r_sync2;
    logic          r_edge;
    logic [2:0]    r_fill;
    logic          w_start;

    // Captured operands and iteration counter
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [2:0]     r_op;
    logic [CW-1:0]  r_cnt;

    // Shift-add multiplier working registers
    logic [RW-1:0]  r_prod;
    logic [RW-1:0]  r_mcand;
    logic [OPW-1:0] r_mplier;

    // Restoring divider working registers
    logic [OPW-1:0] r_rem;
    logic [OPW-1:0] r_quo;

    // Output registers
    logic [RW-1:0]  r_result;
    logic           r_valid;
    logic           r_busy;
    logic           r_neg;
    logic           r_err;

    // Datapath combinational terms
    logic           w_is_iter;
    logic [RW-1:0]  w_mul_prod_next;
    logic [OPW:0]   w_div_shift;
    logic [OPW:0]   w_div_diff;
    logic           w_div_qbit;
    logic [OPW-1:0] w_div_rem_next;
    logic [OPW-1:0] w_div_quo_next;
    logic [OPW-1:0] w_sub_ab;
    logic [OPW-1:0] w_sub_ba;
    logic [RW-1:0]  w_result_next;
    logic           w_neg_next;
    logic           w_err_next;

    // Edge detect is only trusted once sync and edge flops hold real FINISH
    // samples, so a level already high at reset release never looks like a rise.
    assign w_start = r_sync2 & ~r_edge & r_fill[2];

    // Synchronize FINISH and track pipeline fill after reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_fill  <= 3'b000;
        end else begin
            r_sync1 <= FINISH;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_fill  <= {r_fill[1:0], 1'b1};
        end
    end

    assign w_is_iter = (r_op == OP_MUL) || (r_op == OP_DIV);

    // Sequencer state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; START outside IDLE is simply ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (!w_is_iter || (r_cnt == '0)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One shift-add and one restoring-division step per EXEC cycle
    assign w_mul_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_div_shift     = {r_rem, r_quo[OPW-1]};
    assign w_div_diff      = w_div_shift - {1'b0, r_b};
    assign w_div_qbit      = ~w_div_diff[OPW];
    assign w_div_rem_next  = w_div_qbit ? w_div_diff[OPW-1:0] : w_div_shift[OPW-1:0];
    assign w_div_quo_next  = {r_quo[OPW-2:0], w_div_qbit};
    assign w_sub_ab        = r_a - r_b;
    assign w_sub_ba        = r_b - r_a;

    // Capture operands in LOAD, iterate MUL/DIV in EXEC
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_a      <= SRC;
                r_b      <= DST;
                r_op     <= ALU_OP;
                r_cnt    <= CW'(OPW - 1);
                r_prod   <= '0;
                r_mcand  <= RW'(SRC);
                r_mplier <= DST;
                r_rem    <= '0;
                r_quo    <= SRC;
            end else if ((r_state == S_EXEC) && w_is_iter) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                if (r_op == OP_MUL) begin
                    r_prod   <= w_mul_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                end else begin
                    r_rem <= w_div_rem_next;
                    r_quo <= w_div_quo_next;
                end
            end
        end
    end

    // Final result selection, evaluated on the last EXEC cycle
    always_comb begin
        w_result_next = '0;
        w_neg_next    = 1'b0;
        w_err_next    = 1'b0;
        case (r_op)
            OP_PASS: w_result_next = RW'(r_a);
            OP_ADD:  w_result_next = RW'(r_a) + RW'(r_b);
            OP_SUB: begin
                if (r_a >= r_b) begin
                    w_result_next = RW'(w_sub_ab);
                end else begin
                    w_result_next = RW'(w_sub_ba);
                    w_neg_next    = 1'b1;
                end
            end
            OP_MUL:  w_result_next = w_mul_prod_next;
            OP_DIV: begin
                if (r_b == '0) begin
                    w_err_next = 1'b1;
                end else begin
                    w_result_next = {w_div_rem_next, w_div_quo_next};
                end
            end
            OP_AND:  w_result_next = RW'(r_a & r_b);
            OP_OR:   w_result_next = RW'(r_a | r_b);
            OP_XOR:  w_result_next = RW'(r_a ^ r_b);
            default: w_result_next = '0;
        endcase
    end

    // Registered outputs, timed so they are valid during the DONE cycle
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_busy  <= (w_state_next != S_IDLE);
            r_valid <= (w_state_next == S_DONE);
            if (w_state_next == S_DONE) begin
                r_result <= w_result_next;
                r_neg    <= w_neg_next;
                r_err    <= w_err_next;
            end
        end
    end

    assign RESULT = r_result;
    assign VALID  = r_valid;
    assign BUSY   = r_busy;
    assign NEG    = r_neg;
    assign ERR    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against
// an arithmetic reference model.
module tb_alu_sequencer;

    localparam int unsigned W   = 16;
    localparam int          WIN = 26;

    logic            CLK;
    logic            RESET;
    logic [W-1:0]    SRC;
    logic [W-1:0]    DST;
    logic [2:0]      ALU_OP;
    logic            FINISH;
    logic [2*W-1:0]  RESULT;
    logic            VALID;
    logic            BUSY;
    logic            NEG;
    logic            ERR;

    int n_pass  = 0;
    int n_total = 0;

    alu_sequencer #(.OPW(W)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .SRC    (SRC),
        .DST    (DST),
        .ALU_OP (ALU_OP),
        .FINISH (FINISH),
        .RESULT (RESULT),
        .VALID  (VALID),
        .BUSY   (BUSY),
        .NEG    (NEG),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: returns {err, neg, result}
    function automatic logic [2*W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [2:0] op);
        longint unsigned la, lb, res;
        logic neg, err;
        la = longint'(a);
        lb = longint'(b);
        res = 0; neg = 1'b0; err = 1'b0;
        case (op)
            3'd0: res = la;
            3'd1: res = la + lb;
            3'd2: begin
                if (la >= lb) res = la - lb;
                else begin res = lb - la; neg = 1'b1; end
            end
            3'd3: res = la * lb;
            3'd4: begin
                if (lb == 0) err = 1'b1;
                else res = ((la % lb) << W) | (la / lb);
            end
            3'd5: res = la & lb;
            3'd6: res = la | lb;
            default: res = la ^ lb;
        endcase
        return {err, neg, res[2*W-1:0]};
    endfunction

    // Edges from FINISH rise to first VALID: 2 sync edges + 3 or OPW+2 cycles
    function automatic int exp_lat(input logic [2:0] op);
        return (op == 3'd3 || op == 3'd4) ? (2 + W + 2) : 5;
    endfunction

    // Launch one calculation and observe a fixed window of edges
    task automatic do_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input int glitch_at, input int change_at,
                           output int first_e, output int nvalid, output int nbusy,
                           output logic [2*W-1:0] res, output logic neg, output logic err);
        SRC = a; DST = b; ALU_OP = op; FINISH = 1'b1;
        first_e = -1; nvalid = 0; nbusy = 0; res = '0; neg = 1'b0; err = 1'b0;
        for (int e = 1; e <= WIN; e++) begin
            tick();
            if (VALID) begin
                nvalid++;
                if (first_e < 0) begin
                    first_e = e; res = RESULT; neg = NEG; err = ERR;
                end
            end
            if (BUSY) nbusy++;
            if (glitch_at > 0 && e == glitch_at) FINISH = 1'b0;
            if (glitch_at > 0 && e == glitch_at + 3) FINISH = 1'b1;
            if (change_at > 0 && e == change_at) begin
                SRC = W'($urandom); DST = W'($urandom); ALU_OP = 3'($urandom);
            end
        end
        FINISH = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        RESET = 1'b0; FINISH = 1'b0; SRC = '0; DST = '0; ALU_OP = '0;
        repeat (3) tick();
        n_total++;
        if ({RESULT, VALID, BUSY, NEG, ERR} !== '0)
            $display("FAIL reset_outputs: got %h/%b%b%b%b want all zero", RESULT, VALID, BUSY, NEG, ERR);
        else n_pass++;
        RESET = 1'b1;
        repeat (5) tick();
        n_total++;
        if ({VALID, BUSY} !== 2'b00)
            $display("FAIL idle_after_reset: valid/busy got %b%b want 00", VALID, BUSY);
        else n_pass++;
    endtask

    task automatic test_add();
        int fe, nv, nb; logic [2*W-1:0] r; logic ng, er;
        do_calc(16'd123, 16'd45, 3'd1, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (fe !== 5) $display("FAIL add_latency: got %0d want 5", fe); else n_pass++;
        n_total++; if (r !== 32'd168) $display("FAIL add_result: got %0d want 168", r); else n_pass++;
        n_total++; if (ng !== 1'b0) $display("FAIL add_neg: got %b want 0", ng); else n_pass++;
        n_total++; if (nb !== 3) $display("FAIL add_busy_cycles: got %0d want 3", nb); else n_pass++;
        n_total++; if (nv !== 1) $display("FAIL add_valid_count: got %0d want 1", nv); else n_pass++;
    endtask

    task automatic test_sub();
        int fe, nv, nb; logic [2*W-1:0] r; logic ng, er;
        do_calc(16'd5, 16'd9, 3'd2, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (r !== 32'd4 || ng !== 1'b1)
            $display("FAIL sub_neg: got %0d neg %b want 4 neg 1", r, ng); else n_pass++;
        do_calc(16'd9, 16'd5, 3'd2, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (r !== 32'd4 || ng !== 1'b0)
            $display("FAIL sub_pos: got %0d neg %b want 4 neg 0", r, ng); else n_pass++;
    endtask

    task automatic test_mul_ignore_restart();
        int fe, nv, nb; logic [2*W-1:0] r; logic ng, er;
        do_calc(16'd999, 16'd999, 3'd3, 4, -1, fe, nv, nb, r, ng, er);
        n_total++; if (fe !== 20) $display("FAIL mul_latency: got %0d want 20", fe); else n_pass++;
        n_total++; if (r !== 32'd998001) $display("FAIL mul_result: got %0d want 998001", r); else n_pass++;
        n_total++; if (nv !== 1) $display("FAIL mul_valid_count: got %0d want 1", nv); else n_pass++;
        n_total++; if (nb !== 18) $display("FAIL mul_busy_cycles: got %0d want 18", nb); else n_pass++;
    endtask

    task automatic test_div();
        int fe, nv, nb; logic [2*W-1:0] r; logic ng, er;
        do_calc(16'd100, 16'd7, 3'd4, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (r[15:0] !== 16'd14 || r[31:16] !== 16'd2 || er !== 1'b0)
            $display("FAIL div_result: got q %0d r %0d err %b want q 14 r 2 err 0", r[15:0], r[31:16], er);
        else n_pass++;
        do_calc(16'd100, 16'd0, 3'd4, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (fe !== 20) $display("FAIL div0_latency: got %0d want 20", fe); else n_pass++;
        n_total++; if (r !== '0 || er !== 1'b1)
            $display("FAIL div0_result: got %0d err %b want 0 err 1", r, er); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int nv, nb, fe; logic [2*W-1:0] r; logic ng, er;
        SRC = 16'd999; DST = 16'd999; ALU_OP = 3'd3; FINISH = 1'b1;
        repeat (12) tick();
        #2 RESET = 1'b0;
        #1;
        n_total++;
        if ({RESULT, VALID, BUSY, NEG, ERR} !== '0)
            $display("FAIL abort_outputs: got %h/%b%b%b%b want all zero", RESULT, VALID, BUSY, NEG, ERR);
        else n_pass++;
        repeat (2) tick();
        RESET = 1'b1;
        nv = 0; nb = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (VALID) nv++;
            if (BUSY) nb++;
        end
        n_total++; if (nv !== 0 || nb !== 0)
            $display("FAIL held_finish_no_start: valid %0d busy %0d want 0 0", nv, nb); else n_pass++;
        n_total++; if (RESULT !== '0) $display("FAIL abort_result: got %0d want 0", RESULT); else n_pass++;
        FINISH = 1'b0;
        repeat (3) tick();
        do_calc(16'd6, 16'd7, 3'd3, -1, -1, fe, nv, nb, r, ng, er);
        n_total++; if (fe !== 20 || r !== 32'd42)
            $display("FAIL restart_after_reset: lat %0d result %0d want 20 42", fe, r); else n_pass++;
    endtask

    task automatic test_capture();
        int fe, nv, nb; logic [2*W-1:0] r; logic ng, er;
        logic [W-1:0] a, b; logic [2*W+1:0] exp;
        a = W'($urandom); b = W'($urandom);
        exp = ref_model(a, b, 3'd3);
        do_calc(a, b, 3'd3, -1, 6, fe, nv, nb, r, ng, er);
        n_total++; if (r !== exp[2*W-1:0])
            $display("FAIL capture_mul: got %h want %h (a %h b %h)", r, exp[2*W-1:0], a, b); else n_pass++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta [6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd77, 16'hFFFF};
        logic [W-1:0] tb [6] = '{16'hFFFF, 16'hFFFF, 16'd1, 16'd5, 16'd77, 16'hFFFF};
        logic [2:0]   to [6] = '{3'd3, 3'd1, 3'd4, 3'd4, 3'd2, 3'd4};
        for (int i = 0; i < 6; i++) begin
            int fe, nv, nb; logic [2*W-1:0] r; logic ng, er; logic [2*W+1:0] exp;
            exp = ref_model(ta[i], tb[i], to[i]);
            do_calc(ta[i], tb[i], to[i], -1, -1, fe, nv, nb, r, ng, er);
            n_total++;
            if ({er, ng, r} !== exp || fe !== exp_lat(to[i]))
                $display("FAIL boundary_%0d: got err %b neg %b res %h lat %0d want err %b neg %b res %h lat %0d",
                         i, er, ng, r, fe, exp[2*W+1], exp[2*W], exp[2*W-1:0], exp_lat(to[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int fe, nv, nb; logic [2*W-1:0] r; logic ng, er; logic [2*W+1:0] exp;
            logic [W-1:0] a, b; logic [2:0] op;
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 20));
            op = 3'($urandom);
            exp = ref_model(a, b, op);
            do_calc(a, b, op, -1, -1, fe, nv, nb, r, ng, er);
            n_total++;
            if ({er, ng, r} !== exp || fe !== exp_lat(op) || nv !== 1)
                $display("FAIL random_%0d op %0d a %h b %h: got err %b neg %b res %h lat %0d nvalid %0d want err %b neg %b res %h lat %0d",
                         i, op, a, b, er, ng, r, fe, nv, exp[2*W+1], exp[2*W], exp[2*W-1:0], exp_lat(op));
            else n_pass++;
            n_total++;
            if ({ERR, NEG, RESULT} !== exp)
                $display("FAIL random_hold_%0d: got %h want %h", i, {ERR, NEG, RESULT}, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul_ignore_restart();
        test_div();
        test_reset_abort();
        test_capture();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
